// File: rtl/pla_field_decoder_pipe.sv
`timescale 1ns/1ps
// Multi-field one-hot decoder with per-field enable/force, feeding a 2-entry
// valid/ready buffer and a saturating count of delivered words.
module pla_field_decoder_pipe #(
  parameter  int NUM_FIELDS = 4,
  parameter  int FIELD_W    = 4,
  parameter  int CNT_W      = 16,
  localparam int IN_W       = NUM_FIELDS * FIELD_W,
  localparam int GRP        = 1 << FIELD_W,
  localparam int OUT_W      = NUM_FIELDS * GRP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_word,
  input  logic [NUM_FIELDS-1:0] in_en,
  input  logic [NUM_FIELDS-1:0] in_force,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_onehot,
  output logic [NUM_FIELDS-1:0] out_any,
  output logic [CNT_W-1:0]      word_count,
  input  logic                  clear_count
);

  // Handshake: a word moves on any edge where valid && ready; in_ready
  // depends only on occupancy, so a full buffer never refills in the pop cycle.
  localparam int ENT_W = OUT_W + NUM_FIELDS;

  logic [ENT_W-1:0]      mem_q [2];
  logic [ENT_W-1:0]      mem_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic [CNT_W-1:0]      word_count_q, word_count_d;

  logic [OUT_W-1:0]      dec_onehot;
  logic [NUM_FIELDS-1:0] dec_any;
  logic [GRP-1:0]        grp;
  logic [FIELD_W-1:0]    code;
  logic [ENT_W-1:0]      head;
  logic                  push, pop;

  // Force beats enable, enable beats the all-zero default.
  always_comb begin
    dec_onehot = '0;
    dec_any    = '0;
    grp        = '0;
    code       = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      code = in_word[f*FIELD_W +: FIELD_W];
      if (in_force[f])   grp = GRP'(1);
      else if (in_en[f]) grp = GRP'(1) << code;
      else               grp = '0;
      dec_onehot[f*GRP +: GRP] = grp;
      dec_any[f]               = |grp;
    end
  end

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  assign out_onehot = out_valid ? head[ENT_W-1:NUM_FIELDS] : '0;
  assign out_any    = out_valid ? head[NUM_FIELDS-1:0]     : '0;
  assign word_count = word_count_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {dec_onehot, dec_any};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    word_count_d = word_count_q;
    if (clear_count)                        word_count_d = '0;
    else if (pop && (word_count_q != '1))   word_count_d = word_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      word_count_q <= '0;
    end else begin
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      word_count_q <= word_count_d;
    end
  end

endmodule
